// File: rtl/ft_recovery_ctrl.sv
// Recovery controller for an N-core redundant cluster: latches faulty cores, resets them, runs a recovery window, retries on timeout.
// Latency: one cycle from error_i to the RESET/FATAL state; all outputs decode registered state, mask and counter.
// Backpressure: enable_i=0 freezes state, counters and mask; recovery_done_i is only observed in WAIT_DONE.
module ft_recovery_ctrl #(
  parameter int NUM_CORES       = 3,
  parameter int RESET_CYCLES    = 2,
  parameter int RECOVERY_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int MAX_RETRIES     = 2,
  parameter int ERR_CNT_W       = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [NUM_CORES-1:0] error_i,
  input  logic                 recovery_done_i,
  output logic [NUM_CORES-1:0] reset_cores_no,
  output logic                 recover_o,
  output logic                 recovering_o,
  output logic                 load_pc_o,
  output logic [NUM_CORES-1:0] faulty_mask_o,
  output logic                 fatal_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  localparam int MAX_A  = (RESET_CYCLES > RECOVERY_CYCLES) ? RESET_CYCLES : RECOVERY_CYCLES;
  localparam int MAX_C  = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C) + 1;
  localparam int RTY_W  = $clog2(MAX_RETRIES + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RECOVERY,
    S_WAIT_DONE,
    S_FATAL
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RTY_W-1:0]     retry_q, retry_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [NUM_CORES-1:0] merged_mask;
  logic                 new_maj;
  logic                 merged_maj;

  // More than half the cores faulty means the vote can no longer be trusted.
  function automatic logic is_majority(input logic [NUM_CORES-1:0] m);
    int n;
    n = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      n = n + 32'(m[i]);
    end
    return (n > NUM_CORES / 2);
  endfunction

  // Fresh errors and errors merged into the current event, with their majority flags.
  always_comb begin
    merged_mask = mask_q | error_i;
    new_maj     = is_majority(error_i);
    merged_maj  = is_majority(merged_mask);
  end

  // Next-state logic; late errors during recovery widen the mask and can force FATAL.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    mask_d    = mask_q;
    err_cnt_d = err_cnt_q;
    if (enable_i) begin
      case (state_q)
        S_IDLE: begin
          if (|error_i) begin
            mask_d  = error_i;
            cnt_d   = '0;
            retry_d = '0;
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
            state_d = new_maj ? S_FATAL : S_RESET;
          end
        end
        S_RESET: begin
          mask_d = merged_mask;
          cnt_d  = cnt_q + 1'b1;
          if (merged_maj) begin
            state_d = S_FATAL;
          end else if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
            state_d = S_RECOVERY;
            cnt_d   = '0;
          end
        end
        S_RECOVERY: begin
          mask_d = merged_mask;
          cnt_d  = cnt_q + 1'b1;
          if (merged_maj) begin
            state_d = S_FATAL;
          end else if (cnt_q == CNT_W'(RECOVERY_CYCLES - 1)) begin
            state_d = S_WAIT_DONE;
            cnt_d   = '0;
          end
        end
        S_WAIT_DONE: begin
          mask_d = merged_mask;
          cnt_d  = cnt_q + 1'b1;
          if (merged_maj) begin
            state_d = S_FATAL;
          end else if (recovery_done_i) begin
            state_d = S_IDLE;
            mask_d  = '0;
            retry_d = '0;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cnt_d = '0;
            if (retry_q < RTY_W'(MAX_RETRIES)) begin
              retry_d = retry_q + 1'b1;
              state_d = S_RESET;
            end else begin
              state_d = S_FATAL;
            end
          end
        end
        S_FATAL: begin
          state_d = S_FATAL;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, counters and mask; reset aborts any recovery in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      mask_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      mask_q    <= mask_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    reset_cores_no = '1;
    if (state_q == S_FATAL)      reset_cores_no = '0;
    else if (state_q == S_RESET) reset_cores_no = ~mask_q;
    recover_o     = (state_q == S_RECOVERY);
    recovering_o  = (state_q == S_RESET) || (state_q == S_RECOVERY) || (state_q == S_WAIT_DONE);
    load_pc_o     = (state_q == S_IDLE) || (state_q == S_RESET);
    faulty_mask_o = mask_q;
    fatal_o       = (state_q == S_FATAL);
    err_count_o   = err_cnt_q;
  end

endmodule
